// File: rtl/bram_portb_arbiter.sv
// -----------------------------------------------------------------------------
// bram_portb_arbiter
//
// Shares the write-capable port B of the byte-write dual-port BRAM between
// the CPU load/store unit (r0, default priority) and the program loader /
// debug master (r1, which may lock the port for bursts). Each requester has
// a valid/ready request channel and a fixed one-cycle response channel.
// Port A (instruction fetch) is outside this block.
//
// Optional feature macro: BRAM_ARB_ANTISTARVE_EN
//   When defined, a wait counter lets r1 win one contended OPEN cycle after
//   it has waited MAX_WAIT cycles. When undefined, r0 always wins in OPEN.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   r0_valid/ready        CPU request handshake
//   r0_addr/we/wdata      CPU word address, byte write mask (0 = read), data
//   r0_rsp_valid/rdata    CPU response, one cycle after each transfer
//   r1_*                  same set for the loader side
//   r1_lock               with an r1 transfer: 1 = keep the port afterwards
//   mem_en/we/addr/din    to BRAM port B (enaB, weB, addrB, dinB)
//   mem_dout              from BRAM port B, registered, read-first
// -----------------------------------------------------------------------------
module bram_portb_arbiter #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [NUM_COL-1:0]    r0_we,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rsp_valid,
  output logic [DATA_WIDTH-1:0] r0_rsp_rdata,

  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [NUM_COL-1:0]    r1_we,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic                  r1_lock,
  output logic                  r1_rsp_valid,
  output logic [DATA_WIDTH-1:0] r1_rsp_rdata,

  output logic                  mem_en,
  output logic [NUM_COL-1:0]    mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    OPEN   = 2'b00,
    LOCKED = 2'b01
  } ArbState;

  ArbState state;
  ArbState stateNext;

  logic r0Xfer;
  logic r1Xfer;
  logic starveOverride;

  // Catch parameter sets that would break the lane slicing or the counter.
  if (DATA_WIDTH != NUM_COL * COL_WIDTH) begin : gBadWidth
    $error("DATA_WIDTH must equal NUM_COL*COL_WIDTH");
  end
  if (MAX_WAIT < 1) begin : gBadMaxWait
    $error("MAX_WAIT must be at least 1");
  end

  assign r0Xfer = r0_valid & r0_ready;
  assign r1Xfer = r1_valid & r1_ready;

`ifdef BRAM_ARB_ANTISTARVE_EN
  localparam int CNT_WIDTH = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_WAIT);

  logic [CNT_WIDTH-1:0] waitCnt;

  // Counts OPEN cycles in which r1 is left waiting. It only counts in OPEN
  // because a LOCKED port already belongs to r1; any r1 beat restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (r1Xfer) begin
      waitCnt <= '0;
    end else if ((state == OPEN) && r1_valid && !r1_ready && (waitCnt != CNT_MAX)) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  assign starveOverride = (waitCnt == CNT_MAX);
`else
  assign starveOverride = 1'b0;
`endif

  // Grant decision. Ready is forced low while reset is asserted so that no
  // transfer (and hence no BRAM enable) can happen during reset.
  always_comb begin
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if (rst_n) begin
      unique case (state)
        OPEN: begin
          if (r1_valid && (!r0_valid || starveOverride)) begin
            r1_ready = 1'b1;
          end else if (r0_valid) begin
            r0_ready = 1'b1;
          end
        end
        LOCKED: begin
          r1_ready = r1_valid;
        end
        default: begin
          r0_ready = 1'b0;
          r1_ready = 1'b0;
        end
      endcase
    end
  end

  // Lock handling: the lock bit only matters on an actual r1 beat; idle
  // cycles in LOCKED keep the port reserved for the loader.
  always_comb begin
    stateNext = state;
    unique case (state)
      OPEN: begin
        if (r1Xfer && r1_lock) begin
          stateNext = LOCKED;
        end
      end
      LOCKED: begin
        if (r1Xfer && !r1_lock) begin
          stateNext = OPEN;
        end
      end
      default: begin
        stateNext = OPEN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OPEN;
    end else begin
      state <= stateNext;
    end
  end

  // BRAM port B drive: the winner's request goes straight through; with no
  // transfer the port is disabled and all fields are zero.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (r1Xfer) begin
      mem_en   = 1'b1;
      mem_we   = r1_we;
      mem_addr = r1_addr;
      mem_din  = r1_wdata;
    end else if (r0Xfer) begin
      mem_en   = 1'b1;
      mem_we   = r0_we;
      mem_addr = r0_addr;
      mem_din  = r0_wdata;
    end
  end

  // Response valids track the BRAM's one-cycle read latency; writes get a
  // response too (carrying the old word, since the BRAM is read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
    end else begin
      r0_rsp_valid <= r0Xfer;
      r1_rsp_valid <= r1Xfer;
    end
  end

  assign r0_rsp_rdata = r0_rsp_valid ? mem_dout : '0;
  assign r1_rsp_rdata = r1_rsp_valid ? mem_dout : '0;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_portb_arbiter
//
// Drives bram_portb_arbiter against a behavioural read-first byte-write BRAM.
// Cycle vectors carry the requests and the expected ready pattern; a shadow
// memory predicts read data, and expected responses wait in a queue until
// the cycle after their transfer. Honours BRAM_ARB_ANTISTARVE_EN.
// -----------------------------------------------------------------------------
module tb_bram_portb_arbiter;

  localparam int NUM_COL    = 4;
  localparam int COL_WIDTH  = 8;
  localparam int ADDR_WIDTH = 15;
  localparam int DATA_WIDTH = 32;
  localparam int MAX_WAIT   = 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

`ifdef BRAM_ARB_ANTISTARVE_EN
  localparam bit ANTI = 1'b1;
`else
  localparam bit ANTI = 1'b0;
`endif

  typedef struct {
    logic        v0;
    logic [3:0]  we0;
    logic [14:0] a0;
    logic [31:0] d0;
    logic        v1;
    logic [3:0]  we1;
    logic [14:0] a1;
    logic [31:0] d1;
    logic        lk;
    logic        e0;
    logic        e1;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic rst_n;
  logic r0_valid, r0_ready, r0_rsp_valid;
  logic [14:0] r0_addr;
  logic [3:0]  r0_we;
  logic [31:0] r0_wdata, r0_rsp_rdata;
  logic r1_valid, r1_ready, r1_rsp_valid, r1_lock;
  logic [14:0] r1_addr;
  logic [3:0]  r1_we;
  logic [31:0] r1_wdata, r1_rsp_rdata;
  logic mem_en;
  logic [3:0]  mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_din, mem_dout;

  logic [31:0] bram   [0:DEPTH-1];
  logic [31:0] shadow [0:DEPTH-1];
  rsp_t sbQ[$];

  int checkCount = 0;
  int passCount  = 0;

  bram_portb_arbiter #(
    .NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_we(r0_we),
    .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_we(r1_we),
    .r1_wdata(r1_wdata), .r1_lock(r1_lock), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_rdata(r1_rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(int i);
    logic [15:0] lo;
    lo = i[15:0];
    if (i == 5) return 32'h1122_3344;
    return {lo, ~lo};
  endfunction

  // Behavioural BRAM port B: registered, read-first, byte write enables.
  initial begin
    for (int i = 0; i < DEPTH; i++) bram[i] <= initWord(i);
    mem_dout <= '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= bram[mem_addr];
      for (int k = 0; k < NUM_COL; k++) begin
        if (mem_we[k]) bram[mem_addr][k*8 +: 8] <= mem_din[k*8 +: 8];
      end
    end
  end

  function automatic vec_t mkVec(logic v0, logic [3:0] we0, logic [14:0] a0, logic [31:0] d0,
                                 logic v1, logic [3:0] we1, logic [14:0] a1, logic [31:0] d1,
                                 logic lk, logic e0, logic e1);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.lk = lk; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    r0_valid = v.v0; r0_we = v.we0; r0_addr = v.a0; r0_wdata = v.d0;
    r1_valid = v.v1; r1_we = v.we1; r1_addr = v.a1; r1_wdata = v.d1;
    r1_lock  = v.lk;
  endtask

  // Predicts the read-first response word and updates the shadow memory.
  task automatic pushExpected(input logic id, input logic [14:0] a, input logic [3:0] we,
                              input logic [31:0] d);
    rsp_t r;
    r.id = id;
    r.data = shadow[a];
    sbQ.push_back(r);
    for (int k = 0; k < NUM_COL; k++) begin
      if (we[k]) shadow[a][k*8 +: 8] = d[k*8 +: 8];
    end
  endtask

  task automatic checkResponses(input string tag);
    rsp_t r;
    logic e0v, e1v;
    logic [31:0] e0d, e1d;
    e0v = 1'b0; e1v = 1'b0; e0d = '0; e1d = '0;
    while (sbQ.size() > 0) begin
      r = sbQ.pop_front();
      if (r.id == 1'b0) begin
        e0v = 1'b1; e0d = r.data;
      end else begin
        e1v = 1'b1; e1d = r.data;
      end
    end
    checkOutput({tag, " r0_rsp_valid"}, 32'(r0_rsp_valid), 32'(e0v));
    checkOutput({tag, " r0_rsp_rdata"}, r0_rsp_rdata, e0d);
    checkOutput({tag, " r1_rsp_valid"}, 32'(r1_rsp_valid), 32'(e1v));
    checkOutput({tag, " r1_rsp_rdata"}, r1_rsp_rdata, e1d);
  endtask

  // One cycle: drive after the rising edge, check handshake and BRAM drive
  // at the falling edge, check the previous cycle's responses after the edge.
  task automatic runVector(input vec_t v, input string tag);
    logic [3:0]  expWe;
    logic [14:0] expAddr;
    logic [31:0] expDin;
    applyStimulus(v);
    @(negedge clk);
    expWe = 4'b0; expAddr = '0; expDin = '0;
    if (v.e1) begin
      expWe = v.we1; expAddr = v.a1; expDin = v.d1;
    end else if (v.e0) begin
      expWe = v.we0; expAddr = v.a0; expDin = v.d0;
    end
    checkOutput({tag, " r0_ready"}, 32'(r0_ready), 32'(v.e0));
    checkOutput({tag, " r1_ready"}, 32'(r1_ready), 32'(v.e1));
    checkOutput({tag, " mem_en"}, 32'(mem_en), 32'(v.e0 | v.e1));
    checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(expWe));
    if (v.e0 | v.e1) begin
      checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'(expAddr));
      checkOutput({tag, " mem_din"}, mem_din, expDin);
    end
    if (v.e1) pushExpected(1'b1, v.a1, v.we1, v.d1);
    else if (v.e0) pushExpected(1'b0, v.a0, v.we0, v.d0);
    @(posedge clk);
    #1;
    checkResponses(tag);
  endtask

  localparam int NUM_VEC = 16;
  vec_t vecs [NUM_VEC];
  vec_t idle;

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = initWord(i);
    idle = mkVec(0, 4'h0, 15'd0, 32'h0, 0, 4'h0, 15'd0, 32'h0, 0, 0, 0);

    // Write, read-back, alternation, locked burst with an idle beat, contention.
    vecs[0]  = mkVec(1, 4'b0011, 15'd5,   32'hAABBCCDD, 0, 4'h0,    15'd0,   32'h0,        0, 1, 0);
    vecs[1]  = mkVec(1, 4'b0000, 15'd5,   32'h0,        0, 4'h0,    15'd0,   32'h0,        0, 1, 0);
    vecs[2]  = idle;
    vecs[3]  = mkVec(1, 4'b0000, 15'd7,   32'h0,        0, 4'h0,    15'd0,   32'h0,        0, 1, 0);
    vecs[4]  = mkVec(0, 4'b0000, 15'd0,   32'h0,        1, 4'h0,    15'd8,   32'h0,        0, 0, 1);
    vecs[5]  = mkVec(1, 4'b0000, 15'd9,   32'h0,        0, 4'h0,    15'd0,   32'h0,        0, 1, 0);
    vecs[6]  = mkVec(0, 4'b0000, 15'd0,   32'h0,        1, 4'h0,    15'd7,   32'h0,        0, 0, 1);
    vecs[7]  = mkVec(0, 4'b0000, 15'd0,   32'h0,        1, 4'hF,    15'd100, 32'hDEADBEEF, 1, 0, 1);
    vecs[8]  = mkVec(1, 4'b0000, 15'd100, 32'h0,        1, 4'b1100, 15'd101, 32'hCAFEF00D, 1, 0, 1);
    vecs[9]  = mkVec(1, 4'b0000, 15'd100, 32'h0,        0, 4'h0,    15'd0,   32'h0,        0, 0, 0);
    vecs[10] = mkVec(1, 4'b0000, 15'd100, 32'h0,        1, 4'h0,    15'd100, 32'h0,        1, 0, 1);
    vecs[11] = mkVec(1, 4'b0000, 15'd100, 32'h0,        1, 4'h0,    15'd101, 32'h0,        0, 0, 1);
    vecs[12] = mkVec(1, 4'b0000, 15'd100, 32'h0,        0, 4'h0,    15'd0,   32'h0,        0, 1, 0);
    vecs[13] = mkVec(1, 4'b0000, 15'd5,   32'h0,        1, 4'h0,    15'd5,   32'h0,        0, 1, 0);
    vecs[14] = mkVec(0, 4'b0000, 15'd0,   32'h0,        1, 4'h0,    15'd5,   32'h0,        0, 0, 1);
    vecs[15] = idle;

    // Reset with both requesters asserting: nothing may be granted.
    rst_n = 1'b0;
    applyStimulus(mkVec(1, 4'h0, 15'd3, 32'h0, 1, 4'h0, 15'd4, 32'h0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst r0_ready", 32'(r0_ready), 32'd0);
    checkOutput("rst r1_ready", 32'(r1_ready), 32'd0);
    checkOutput("rst mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
    checkOutput("rst r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
    applyStimulus(idle);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NUM_VEC; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a locked burst: the in-flight beat is dropped.
    runVector(mkVec(0, 4'h0, 15'd0, 32'h0, 1, 4'h0, 15'd200, 32'h0, 1, 0, 1), "burst1");
    applyStimulus(mkVec(1, 4'h0, 15'd3, 32'h0, 1, 4'hF, 15'd201, 32'h12345678, 1, 0, 0));
    @(negedge clk);
    checkOutput("midrst pre r1_ready", 32'(r1_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst mem_en", 32'(mem_en), 32'd0);
    checkOutput("midrst r0_ready", 32'(r0_ready), 32'd0);
    checkOutput("midrst r1_ready", 32'(r1_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
    checkOutput("midrst r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
    checkOutput("midrst mem_en2", 32'(mem_en), 32'd0);
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Back in OPEN: the CPU wins against a simultaneous loader request.
    runVector(mkVec(1, 4'h0, 15'd5, 32'h0, 1, 4'h0, 15'd201, 32'h0, 0, 1, 0), "postrst open");
    runVector(mkVec(0, 4'h0, 15'd0, 32'h0, 1, 4'h0, 15'd201, 32'h0, 0, 0, 1), "postrst r1");
    runVector(idle, "postrst idle");

    // Continuous contention: strict r0 priority, or one r1 win on cycle 9.
    for (int i = 1; i <= 12; i++) begin
      logic winR1;
      winR1 = ANTI && (i == MAX_WAIT + 1);
      runVector(mkVec(1, 4'h0, 15'd10, 32'h0, 1, 4'h0, 15'd20, 32'h0, 0, !winR1, winR1),
                $sformatf("contend%0d", i));
    end
    runVector(idle, "final idle");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
